// File: rtl/gpu_instr_pkg.sv
// Shared types for the draw-instruction path: the packed instruction word
// carried through the queue and the opcode encoding used by the decoder.
package gpu_instr_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_LINE   = 4'h1,
    OP_RECT   = 4'h2,
    OP_CIRCLE = 4'h3,
    OP_FILL   = 4'h4,
    OP_CLEAR  = 4'h5
  } opcode_t;

  // Field order runs MSB to LSB; the coordinates match the 10-bit screen space
  typedef struct packed {
    logic [2:0] oct;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] rad;
    logic [9:0] y2;
    logic [9:0] x2;
    logic [9:0] y1;
    logic [9:0] x1;
    logic [3:0] opcode;
  } instr_t;

  localparam int INSTR_WIDTH = $bits(instr_t);

endpackage

// File: rtl/gpu_instruction_queue_if.sv
// Handshake and status bundle between the command decoder (master) and the
// instruction queue (slave).
interface gpu_instruction_queue_if
  import gpu_instr_pkg::*;
#(
  parameter int DATA_WIDTH = INSTR_WIDTH,
  parameter int DEPTH      = 8
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  push_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  pop_i;
  logic                  flush_i;
  logic                  clear_err_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  empty_o;
  logic                  full_o;
  logic                  almost_empty_o;
  logic                  almost_full_o;
  logic [CW-1:0]         count_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output push_i, data_i, pop_i, flush_i, clear_err_i,
    input  data_o, empty_o, full_o, almost_empty_o, almost_full_o,
           count_o, overflow_o, underflow_o
  );

  modport slave (
    input  push_i, data_i, pop_i, flush_i, clear_err_i,
    output data_o, empty_o, full_o, almost_empty_o, almost_full_o,
           count_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/gpu_queue_mem.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Entries are deliberately left unreset; validity is tracked by the queue count.
module gpu_queue_mem #(
  parameter int DATA_WIDTH = 79,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/gpu_instruction_queue.sv
// Show-ahead instruction queue between the command decoder and the rasteriser
// dispatcher, with thresholds, occupancy, synchronous flush and sticky errors.
module gpu_instruction_queue
  import gpu_instr_pkg::*;
#(
  parameter int DATA_WIDTH = INSTR_WIDTH,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input logic                  clk,
  input logic                  n_rst,
  gpu_instruction_queue_if.slave q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;
  logic                  empty;
  logic                  full;
  logic                  pop_acc;
  logic                  push_acc;
  logic                  ovf_set;
  logic                  unf_set;
  logic [DATA_WIDTH-1:0] rd_data;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // Flush overrides everything, so requests arriving with it are neither
  // accepted nor counted as errors.
  assign pop_acc  = q.pop_i & ~empty & ~q.flush_i;
  assign push_acc = q.push_i & (~full | pop_acc) & ~q.flush_i;
  assign ovf_set  = q.push_i & ~push_acc & ~q.flush_i;
  assign unf_set  = q.pop_i & empty & ~q.flush_i;

  gpu_queue_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr),
    .wr_data (q.data_i),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (q.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new error event takes precedence over a coincident clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)            overflow <= 1'b1;
      else if (q.clear_err_i) overflow <= 1'b0;
      if (unf_set)            underflow <= 1'b1;
      else if (q.clear_err_i) underflow <= 1'b0;
    end
  end

  assign q.data_o         = empty ? '0 : rd_data;
  assign q.empty_o        = empty;
  assign q.full_o         = full;
  assign q.almost_empty_o = (count <= AE_C);
  assign q.almost_full_o  = (count >= AF_C);
  assign q.count_o        = count;
  assign q.overflow_o     = overflow;
  assign q.underflow_o    = underflow;

endmodule

// File: tb/tb_gpu_instruction_queue.sv
// Scenario bench for gpu_instruction_queue, checked against a queue-based
// reference model of the occupancy, ordering and error-flag rules.
module tb_gpu_instruction_queue;
  import gpu_instr_pkg::*;

  localparam int DW    = INSTR_WIDTH;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic n_rst;

  gpu_instruction_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  gpu_instruction_queue #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (DEPTH - 2),
    .AE_THRESH  (1)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .q     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  logic [DW-1:0] mq [$];
  bit            m_ovf;
  bit            m_unf;

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [DW-1:0] exp_data();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  // Apply one cycle of requests, advance the model on the edge, sample at +1.
  task automatic drive(input bit pu, input logic [DW-1:0] d, input bit po,
                       input bit fl, input bit cl);
    bit pa;
    bit pacc;
    bus.push_i      = pu;
    bus.data_i      = d;
    bus.pop_i       = po;
    bus.flush_i     = fl;
    bus.clear_err_i = cl;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      if (cl) begin
        m_ovf = 0;
        m_unf = 0;
      end
    end else begin
      pa   = po && (mq.size() > 0);
      pacc = pu && ((mq.size() < DEPTH) || pa);
      if (po && mq.size() == 0) m_unf = 1;
      else if (cl)              m_unf = 0;
      if (pu && !pacc)          m_ovf = 1;
      else if (cl)              m_ovf = 0;
      if (pa)   void'(mq.pop_front());
      if (pacc) mq.push_back(d);
    end
    #1;
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, 0);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.push_i = 0; bus.data_i = '0; bus.pop_i = 0;
    bus.flush_i = 0; bus.clear_err_i = 0;
    mq.delete(); m_ovf = 0; m_unf = 0;
    #17 n_rst = 1'b1;
    @(posedge clk); #1;
    idle();
    total++;
    if (bus.empty_o !== 1'b1 || bus.almost_empty_o !== 1'b1 || bus.full_o !== 1'b0 ||
        bus.almost_full_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got e=%b ae=%b f=%b af=%b want 1 1 0 0",
               bus.empty_o, bus.almost_empty_o, bus.full_o, bus.almost_full_o);
    end
    total++;
    if (bus.count_o !== '0 || bus.data_o !== '0) begin
      bad++;
      $display("[TB] FAIL reset_count_data: got count=%0d data=%h want 0 0", bus.count_o, bus.data_o);
    end
    total++;
    if (bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_err: got ovf=%b unf=%b want 0 0", bus.overflow_o, bus.underflow_o);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1, DW'(i), 0, 0, 0);
      total++;
      if (bus.count_o !== CW'(i) || bus.almost_full_o !== (i >= DEPTH - 2)) begin
        bad++;
        $display("[TB] FAIL fill_%0d: got count=%0d af=%b want %0d %b",
                 i, bus.count_o, bus.almost_full_o, i, (i >= DEPTH - 2));
      end
    end
    total++;
    if (bus.full_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_flag: got %b want 1", bus.full_o);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      total++;
      if (bus.data_o !== DW'(i)) begin
        bad++;
        $display("[TB] FAIL drain_%0d: got %h want %h", i, bus.data_o, DW'(i));
      end
      drive(0, '0, 1, 0, 0);
    end
    total++;
    if (bus.empty_o !== 1'b1 || bus.underflow_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drain_empty: got e=%b unf=%b want 1 0", bus.empty_o, bus.underflow_o);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) drive(1, DW'(8'h11 + i), 0, 0, 0);
    drive(1, DW'(8'h55), 0, 0, 0);
    total++;
    if (bus.overflow_o !== 1'b1 || bus.count_o !== CW'(DEPTH)) begin
      bad++;
      $display("[TB] FAIL push_full: got ovf=%b count=%0d want 1 %0d", bus.overflow_o, bus.count_o, DEPTH);
    end
    drive(1, DW'(8'h66), 1, 0, 0);
    total++;
    if (bus.count_o !== CW'(DEPTH) || bus.data_o !== exp_data()) begin
      bad++;
      $display("[TB] FAIL push_pop_full: got count=%0d data=%h want %0d %h",
               bus.count_o, bus.data_o, DEPTH, exp_data());
    end
    for (int i = 0; i < DEPTH - 1; i++) drive(0, '0, 1, 0, 0);
    total++;
    if (bus.data_o !== DW'(8'h66) || bus.count_o !== CW'(1)) begin
      bad++;
      $display("[TB] FAIL reused_slot: got data=%h count=%0d want 66 1", bus.data_o, bus.count_o);
    end
    drive(0, '0, 1, 0, 1);
    total++;
    if (bus.overflow_o !== 1'b0 || bus.empty_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovf_clear: got ovf=%b e=%b want 0 1", bus.overflow_o, bus.empty_o);
    end
  endtask

  task automatic test_underflow();
    drive(0, '0, 1, 0, 0);
    total++;
    if (bus.underflow_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pop_empty: got unf=%b want 1", bus.underflow_o);
    end
    drive(1, DW'(8'h2A), 1, 0, 0);
    total++;
    if (bus.count_o !== CW'(1) || bus.data_o !== DW'(8'h2A)) begin
      bad++;
      $display("[TB] FAIL push_pop_empty: got count=%0d data=%h want 1 2a", bus.count_o, bus.data_o);
    end
    drive(0, '0, 0, 0, 1);
    total++;
    if (bus.underflow_o !== 1'b0 || bus.overflow_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clear_err: got ovf=%b unf=%b want 0 0", bus.overflow_o, bus.underflow_o);
    end
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 1);
    total++;
    if (bus.underflow_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL set_beats_clear: got unf=%b want 1", bus.underflow_o);
    end
    drive(0, '0, 0, 0, 1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) drive(1, rand_word(), 0, 0, 0);
    drive(1, DW'(8'h77), 1, 1, 0);
    total++;
    if (bus.count_o !== '0 || bus.empty_o !== 1'b1 || bus.overflow_o !== 1'b0 ||
        bus.underflow_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush: got count=%0d e=%b ovf=%b unf=%b want 0 1 0 0",
               bus.count_o, bus.empty_o, bus.overflow_o, bus.underflow_o);
    end
    drive(1, DW'(8'h10), 0, 0, 0);
    total++;
    if (bus.data_o !== DW'(8'h10) || bus.count_o !== CW'(1)) begin
      bad++;
      $display("[TB] FAIL after_flush: got data=%h count=%0d want 10 1", bus.data_o, bus.count_o);
    end
    drive(0, '0, 1, 0, 0);
  endtask

  task automatic test_wrap_reset();
    logic [DW-1:0] pat;
    pat = DW'(8'h80);
    for (int i = 0; i < 20; i++) begin
      drive(1, pat, (i >= 3) && ($urandom_range(0, 3) != 0), 0, 0);
      pat = pat + 1'b1;
      total++;
      if (bus.data_o !== exp_data() || bus.count_o !== CW'(mq.size())) begin
        bad++;
        $display("[TB] FAIL wrap_%0d: got data=%h count=%0d want %h %0d",
                 i, bus.data_o, bus.count_o, exp_data(), mq.size());
      end
    end
    bus.push_i = 1; bus.pop_i = 0;
    #2 n_rst = 1'b0;
    #1;
    mq.delete(); m_ovf = 0; m_unf = 0;
    total++;
    if (bus.count_o !== '0 || bus.empty_o !== 1'b1 || bus.data_o !== '0 ||
        bus.full_o !== 1'b0 || bus.almost_full_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset: got count=%0d e=%b data=%h f=%b af=%b want 0 1 0 0 0",
               bus.count_o, bus.empty_o, bus.data_o, bus.full_o, bus.almost_full_o);
    end
    bus.push_i = 0;
    #2 n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit pu, po, fl, cl;
    for (int i = 0; i < 300; i++) begin
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 31) == 0);
      cl = ($urandom_range(0, 15) == 0);
      drive(pu, rand_word(), po, fl, cl);
      total++;
      if (bus.data_o !== exp_data() || bus.count_o !== CW'(mq.size()) ||
          bus.empty_o !== (mq.size() == 0) || bus.full_o !== (mq.size() == DEPTH) ||
          bus.almost_empty_o !== (mq.size() <= 1) || bus.almost_full_o !== (mq.size() >= DEPTH - 2) ||
          bus.overflow_o !== m_ovf || bus.underflow_o !== m_unf) begin
        bad++;
        $display("[TB] FAIL random_%0d: got cnt=%0d data=%h ovf=%b unf=%b want %0d %h %b %b",
                 i, bus.count_o, bus.data_o, bus.overflow_o, bus.underflow_o,
                 mq.size(), exp_data(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_flush();
    test_wrap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
